// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: synchronises the NMI/IRQ pins, latches NMI edges and
// BRK requests, and at each instruction boundary grants one source as a
// one-hot vector select held until the sequencer acknowledges the fetch.
//
// Handshake: a grant is offered on vectorSelect/busy one cycle after a
// sample strobe that finds an active source; it stays stable until ack is
// seen high on a rising edge while busy=1, after which busy drops next cycle.
module interrupt_arbiter #(
    parameter int SYNC_STAGES  = 2,
    parameter int VECTOR_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    nmiIn,
    input  logic                    irqIn,
    input  logic                    brkReq,
    input  logic                    iFlag,
    input  logic                    sample,
    input  logic                    ack,
    output logic [VECTOR_COUNT-1:0] vectorSelect,
    output logic                    busy,
    output logic                    pending,
    output logic                    fsmState
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [VECTOR_COUNT-1:0] SEL_RESET = VECTOR_COUNT'(1);
    localparam logic [VECTOR_COUNT-1:0] SEL_NMI   = VECTOR_COUNT'(2);
    localparam logic [VECTOR_COUNT-1:0] SEL_BRK   = VECTOR_COUNT'(4);
    localparam logic [VECTOR_COUNT-1:0] SEL_IRQ   = VECTOR_COUNT'(8);

    state_t                  state;
    state_t                  stateNext;
    logic [VECTOR_COUNT-1:0] selNext;
    logic [SYNC_STAGES-1:0]  nmiSyncQ;
    logic [SYNC_STAGES-1:0]  irqSyncQ;
    logic                    nmiSync;
    logic                    irqSync;
    logic                    nmiPrev;
    logic                    nmiFall;
    logic                    nmiLatch;
    logic                    brkLatch;
    logic                    irqActive;
    logic                    anySource;
    logic                    clrNmi;
    logic                    clrBrk;

    assign nmiSync   = nmiSyncQ[SYNC_STAGES-1];
    assign irqSync   = irqSyncQ[SYNC_STAGES-1];
    assign nmiFall   = nmiPrev & ~nmiSync;
    assign irqActive = ~irqSync & ~iFlag;
    assign anySource = nmiLatch | brkLatch | irqActive;
    assign busy      = (state == GRANT);
    assign fsmState  = state;

    // Pin synchronisers plus the NMI edge-detect flop; all idle high.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            nmiSyncQ <= '1;
            irqSyncQ <= '1;
            nmiPrev  <= 1'b1;
        end else begin
            nmiSyncQ <= {nmiSyncQ[SYNC_STAGES-2:0], nmiIn};
            irqSyncQ <= {irqSyncQ[SYNC_STAGES-2:0], irqIn};
            nmiPrev  <= nmiSync;
        end
    end

    // Request latches: a new set in the clearing cycle wins over the clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            nmiLatch <= 1'b0;
            brkLatch <= 1'b0;
            pending  <= 1'b0;
        end else begin
            nmiLatch <= nmiFall | (nmiLatch & ~clrNmi);
            brkLatch <= brkReq  | (brkLatch & ~clrBrk);
            pending  <= anySource;
        end
    end

    // FSM state and held grant register; reset forces the reset-vector grant.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= GRANT;
            vectorSelect <= SEL_RESET;
        end else begin
            state        <= stateNext;
            vectorSelect <= selNext;
        end
    end

    // Next-state, priority select and latch-clear decode.
    always_comb begin
        stateNext = state;
        selNext   = vectorSelect;
        clrNmi    = 1'b0;
        clrBrk    = 1'b0;
        case (state)
            IDLE: begin
                selNext = '0;
                if (sample && anySource) begin
                    stateNext = GRANT;
                    if (nmiLatch)      selNext = SEL_NMI;
                    else if (brkLatch) selNext = SEL_BRK;
                    else               selNext = SEL_IRQ;
                end
            end
            GRANT: begin
                if (ack) begin
                    stateNext = IDLE;
                    selNext   = '0;
                    clrNmi    = (vectorSelect == SEL_NMI);
                    clrBrk    = (vectorSelect == SEL_BRK);
                end
            end
            default: begin
                stateNext = IDLE;
                selNext   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: grants are predicted when a sample
// strobe is driven and compared one cycle later against the DUT output.
module tb_interrupt_arbiter;

  logic       clk = 1'b0;
  logic       nrst;
  logic       nmi_in;
  logic       irq_in;
  logic       brk_req;
  logic       i_flag;
  logic       sample;
  logic       ack;
  logic [3:0] vector_select;
  logic       busy;
  logic       pending;
  logic       fsm_state;

  logic [3:0] exp_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;

  interrupt_arbiter #(.SYNC_STAGES(2), .VECTOR_COUNT(4)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .nmiIn        (nmi_in),
    .irqIn        (irq_in),
    .brkReq       (brk_req),
    .iFlag        (i_flag),
    .sample       (sample),
    .ack          (ack),
    .vectorSelect (vector_select),
    .busy         (busy),
    .pending      (pending),
    .fsmState     (fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance n rising edges, landing 1ns after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver: one-cycle sample strobe, prediction pushed, result popped next cycle
  task automatic pulse_sample(input logic [3:0] exp, input string tag);
    logic [3:0] e;
    sample = 1'b1;
    exp_q.push_back(exp);
    tick(1);
    sample = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sel"}, 32'(vector_select), 32'(e));
      check({tag, "_busy"}, 32'(busy), 32'(e != 4'b0000));
    end
  endtask

  task automatic pulse_ack(input string tag);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check({tag, "_sel"}, 32'(vector_select), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    nrst    = 1'b1;
    nmi_in  = 1'b1;
    irq_in  = 1'b1;
    brk_req = 1'b0;
    i_flag  = 1'b0;
    sample  = 1'b0;
    ack     = 1'b0;
    #2 nrst = 1'b0;
    #1;
    check("rst_sel", 32'(vector_select), 32'h1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_pending", 32'(pending), 32'd0);

    // 1: reset release, reset vector held until ack
    tick(3);
    nrst = 1'b1;
    tick(2);
    check("rel_sel", 32'(vector_select), 32'h1);
    check("rel_state", 32'(fsm_state), 32'd1);
    pulse_sample(4'b0001, "rel_sample_ignored");
    pulse_ack("rel_ack");
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("idle_ack_ignored", 32'(vector_select), 32'd0);

    // 2: NMI edge, held low produces one request only
    nmi_in = 1'b0;
    tick(5);
    check("nmi_pending", 32'(pending), 32'd1);
    pulse_sample(4'b0010, "nmi1");
    pulse_ack("nmi1_ack");
    pulse_sample(4'b0000, "nmi_held");
    check("nmi_held_pending", 32'(pending), 32'd0);
    tick(12);
    nmi_in = 1'b1;
    tick(4);
    nmi_in = 1'b0;
    tick(5);
    pulse_sample(4'b0010, "nmi2");
    pulse_ack("nmi2_ack");
    nmi_in = 1'b1;
    tick(4);

    // 3: IRQ masking by iFlag
    irq_in = 1'b0;
    i_flag = 1'b1;
    tick(3);
    pulse_sample(4'b0000, "irq_masked");
    check("irq_masked_pending", 32'(pending), 32'd0);
    i_flag = 1'b0;
    pulse_sample(4'b1000, "irq");
    pulse_ack("irq_ack");
    irq_in = 1'b1;
    tick(3);
    check("irq_gone_pending", 32'(pending), 32'd0);

    // 4: priority NMI > BRK > IRQ, lower latches persist
    brk_req = 1'b1;
    tick(1);
    brk_req = 1'b0;
    nmi_in = 1'b0;
    irq_in = 1'b0;
    tick(5);
    pulse_sample(4'b0010, "pri_nmi");
    pulse_ack("pri_nmi_ack");
    pulse_sample(4'b0100, "pri_brk");
    pulse_ack("pri_brk_ack");
    pulse_sample(4'b1000, "pri_irq");
    pulse_ack("pri_irq_ack");
    irq_in = 1'b1;
    nmi_in = 1'b1;
    tick(4);

    // 5: NMI edge landing in the ack cycle keeps the latch set
    nmi_in = 1'b0;
    tick(5);
    pulse_sample(4'b0010, "sd_first");
    nmi_in = 1'b1;
    tick(4);
    nmi_in = 1'b0;
    tick(2);
    pulse_ack("sd_ack");
    tick(1);
    check("sd_pending", 32'(pending), 32'd1);
    pulse_sample(4'b0010, "sd_second");
    pulse_ack("sd_second_ack");
    nmi_in = 1'b1;
    tick(4);

    // sample coincident with ack in GRANT: ack honoured, sample ignored
    brk_req = 1'b1;
    tick(1);
    brk_req = 1'b0;
    pulse_sample(4'b0100, "co_brk");
    irq_in = 1'b0;
    tick(3);
    sample = 1'b1;
    ack = 1'b1;
    tick(1);
    sample = 1'b0;
    ack = 1'b0;
    check("co_sel", 32'(vector_select), 32'd0);
    tick(1);
    check("co_still_idle", 32'(busy), 32'd0);
    irq_in = 1'b1;
    tick(3);

    // 6: mid-grant reset abandons BRK and clears its latch
    brk_req = 1'b1;
    tick(1);
    brk_req = 1'b0;
    pulse_sample(4'b0100, "mr_brk");
    nrst = 1'b0;
    #1;
    check("mr_async_sel", 32'(vector_select), 32'h1);
    check("mr_async_busy", 32'(busy), 32'd1);
    tick(1);
    nrst = 1'b1;
    tick(1);
    check("mr_hold_sel", 32'(vector_select), 32'h1);
    pulse_ack("mr_ack");
    pulse_sample(4'b0000, "mr_no_brk");
    check("mr_pending", 32'(pending), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
